// File: rtl/control_fsm.sv
// control_fsm
//   Multicycle control unit sitting right after instruction fetch. It captures
//   the fetched word into IR, decodes the opcode and walks the datapath through
//   IF/DEC/EXEC/MEM/WB/BR. Outputs are Moore-decoded from the registered state
//   and IR. The one exception is PC_Sel in S_BR, which also looks at Zero.
//
//   Ports
//     Clk, Reset          clock (rising edge), async active-low reset
//     Instr[31:0]         fetched word, captured at the end of S_IF
//     Zero                ALU zero flag, used in S_BR
//     IR[31:0]            instruction register
//     PC_Sel, PC_LdEn     next-PC select / load strobe back to fetch
//     RF_WrEn, RF_WrData_sel, RF_B_sel   register-file controls
//     ALU_Bin_sel, ALU_func[3:0]         ALU operand/op controls
//     Mem_WrEn, ByteOp    data-memory write strobe / byte access
//     Illegal             sticky illegal-opcode flag
module control_fsm #(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Instr,
  input  logic        Zero,
  output logic [31:0] IR,
  output logic        PC_Sel,
  output logic        PC_LdEn,
  output logic        RF_WrEn,
  output logic        RF_WrData_sel,
  output logic        RF_B_sel,
  output logic        ALU_Bin_sel,
  output logic [3:0]  ALU_func,
  output logic        Mem_WrEn,
  output logic        ByteOp,
  output logic        Illegal
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_DEC  = 3'd1,
    S_EXEC = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_BR   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic        illegal_q, illegal_d;

  logic [5:0]  op;
  logic        is_alur, is_alui, is_br, is_ld, is_st, is_byte, is_legal;
  logic        br_taken;
  logic [3:0]  alu_code;

  assign op = ir_q[31:26];

  // Opcode classification
  always_comb begin
    is_alur  = (op == 6'b100000);
    is_alui  = op inside {6'b111000, 6'b111001, 6'b110000, 6'b110010, 6'b110011};
    is_br    = op inside {6'b111111, 6'b000000, 6'b000001};
    is_ld    = op inside {6'b000011, 6'b001111};
    is_st    = op inside {6'b000111, 6'b011111};
    is_byte  = (op == 6'b000011) || (op == 6'b000111);
    is_legal = is_alur || is_alui || is_br || is_ld || is_st;
  end

  // Immediates arrive pre-shifted for lui, so lui, li, addi and ld/st all use add.
  always_comb begin
    alu_code = 4'b0000;
    if (is_alur)                alu_code = ir_q[3:0];
    else if (op == 6'b110010)   alu_code = 4'b0010;
    else if (op == 6'b110011)   alu_code = 4'b0011;
    else if (is_br)             alu_code = 4'b0001;
  end

  assign br_taken = (op == 6'b111111) ||
                    ((op == 6'b000000) &&  Zero) ||
                    ((op == 6'b000001) && !Zero);

  // Next-state / IR / sticky flag
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IF: begin
        ir_d    = Instr;
        state_d = S_DEC;
      end
      S_DEC: begin
        if (is_alur || is_alui || is_ld || is_st) state_d = S_EXEC;
        else if (is_br)                           state_d = S_BR;
        else begin
          illegal_d = 1'b1;
          state_d   = ILLEGAL_HALT ? S_HALT : S_IF;
        end
      end
      S_EXEC:  state_d = (is_ld || is_st) ? S_MEM : S_WB;
      S_MEM:   state_d = is_st ? S_IF : S_WB;
      S_WB:    state_d = S_IF;
      S_BR:    state_d = S_IF;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IF;
      ir_q      <= 32'h0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  // Moore decode. Reset forces S_IF with IR=0, so every strobe drops
  // asynchronously as soon as Reset falls.
  always_comb begin
    PC_Sel        = 1'b0;
    PC_LdEn       = 1'b0;
    RF_WrEn       = 1'b0;
    RF_WrData_sel = 1'b0;
    RF_B_sel      = 1'b0;
    ALU_Bin_sel   = 1'b0;
    ALU_func      = 4'b0000;
    Mem_WrEn      = 1'b0;
    ByteOp        = 1'b0;
    case (state_q)
      S_DEC: begin
        RF_B_sel = is_legal && !is_alur;
        // The illegal-as-NOP path retires from DEC with a plain PC+4.
        if (!is_legal && !ILLEGAL_HALT) PC_LdEn = 1'b1;
      end
      S_EXEC: begin
        RF_B_sel    = !is_alur;
        ALU_Bin_sel = is_alui || is_ld || is_st;
        ALU_func    = alu_code;
      end
      S_MEM: begin
        RF_B_sel = is_st;
        Mem_WrEn = is_st;
        PC_LdEn  = is_st;
        ByteOp   = is_byte;
      end
      S_WB: begin
        RF_WrEn       = 1'b1;
        RF_WrData_sel = is_ld;
        PC_LdEn       = 1'b1;
        ByteOp        = is_byte;
      end
      S_BR: begin
        RF_B_sel = 1'b1;
        ALU_func = alu_code;
        PC_LdEn  = 1'b1;
        PC_Sel   = br_taken;
      end
      default: ;
    endcase
  end

  assign IR      = ir_q;
  assign Illegal = illegal_q;

endmodule

// File: tb/tb_control_fsm.sv
module tb_control_fsm;
  logic        Clk, Reset, Zero;
  logic [31:0] Instr;

  logic [31:0] IR, h_IR;
  logic        PC_Sel, PC_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel;
  logic        Mem_WrEn, ByteOp, Illegal;
  logic [3:0]  ALU_func;
  logic        h_PC_Sel, h_PC_LdEn, h_RF_WrEn, h_RF_WrData_sel, h_RF_B_sel, h_ALU_Bin_sel;
  logic        h_Mem_WrEn, h_ByteOp, h_Illegal;
  logic [3:0]  h_ALU_func;

  int n_checks = 0;
  int n_errors = 0;

  // Expected per-cycle output vectors: {ld, sel, wr, wsel, mw, bo, bin, func[3:0]}
  logic [10:0] sb_q[$];
  logic [10:0] obs, h_obs;

  assign obs   = {PC_LdEn, PC_Sel, RF_WrEn, RF_WrData_sel, Mem_WrEn, ByteOp, ALU_Bin_sel, ALU_func};
  assign h_obs = {h_PC_LdEn, h_PC_Sel, h_RF_WrEn, h_RF_WrData_sel, h_Mem_WrEn, h_ByteOp,
                  h_ALU_Bin_sel, h_ALU_func};

  control_fsm #(.ILLEGAL_HALT(1'b0)) dut (
    .Clk(Clk), .Reset(Reset), .Instr(Instr), .Zero(Zero), .IR(IR),
    .PC_Sel(PC_Sel), .PC_LdEn(PC_LdEn), .RF_WrEn(RF_WrEn), .RF_WrData_sel(RF_WrData_sel),
    .RF_B_sel(RF_B_sel), .ALU_Bin_sel(ALU_Bin_sel), .ALU_func(ALU_func),
    .Mem_WrEn(Mem_WrEn), .ByteOp(ByteOp), .Illegal(Illegal)
  );

  control_fsm #(.ILLEGAL_HALT(1'b1)) dut_h (
    .Clk(Clk), .Reset(Reset), .Instr(Instr), .Zero(Zero), .IR(h_IR),
    .PC_Sel(h_PC_Sel), .PC_LdEn(h_PC_LdEn), .RF_WrEn(h_RF_WrEn), .RF_WrData_sel(h_RF_WrData_sel),
    .RF_B_sel(h_RF_B_sel), .ALU_Bin_sel(h_ALU_Bin_sel), .ALU_func(h_ALU_func),
    .Mem_WrEn(h_Mem_WrEn), .ByteOp(h_ByteOp), .Illegal(h_Illegal)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [10:0] ev(input logic ld, input logic sel, input logic wr,
                                     input logic wsel, input logic mw, input logic bo,
                                     input logic bin, input logic [3:0] fn);
    return {ld, sel, wr, wsel, mw, bo, bin, fn};
  endfunction

  // Drive one cycle at the falling edge, then settle before sampling.
  task automatic cyc(input logic [31:0] ins, input logic z);
    @(negedge Clk);
    Instr = ins;
    Zero  = z;
    #1;
  endtask

  task automatic test_reset;
    Reset = 1'b0; Instr = 32'h8000_0000; Zero = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk); #1;
    n_checks++; if (obs !== 11'h0)   begin n_errors++; $display("FAIL reset_outs got %b exp %b", obs, 11'h0); end
    n_checks++; if (IR !== 32'h0)    begin n_errors++; $display("FAIL reset_ir got %h exp 0", IR); end
    n_checks++; if (Illegal !== 1'b0) begin n_errors++; $display("FAIL reset_illegal got %b exp 0", Illegal); end
    @(posedge Clk); #2;
    Reset = 1'b1;
  endtask

  task automatic test_alu_r;
    logic [10:0] e;
    sb_q.push_back(11'h0); sb_q.push_back(11'h0); sb_q.push_back(ev(0,0,0,0,0,0,0,4'h0));
    sb_q.push_back(ev(1,0,1,0,0,0,0,4'h0));
    for (int i = 0; i < 4; i++) begin
      cyc(32'h8000_0000, 1'b0);
      e = sb_q.pop_front();
      n_checks++;
      if (obs !== e) begin n_errors++; $display("FAIL alu_r cyc%0d got %b exp %b", i+1, obs, e); end
      if (i == 1) begin
        n_checks++; if (IR !== 32'h8000_0000) begin n_errors++; $display("FAIL alu_r_ir got %h exp 80000000", IR); end
        n_checks++; if (RF_B_sel !== 1'b0)    begin n_errors++; $display("FAIL alu_r_bsel got %b exp 0", RF_B_sel); end
      end
    end
  endtask

  task automatic test_load;
    logic [10:0] e;
    sb_q.push_back(11'h0); sb_q.push_back(11'h0); sb_q.push_back(ev(0,0,0,0,0,0,1,4'h0));
    sb_q.push_back(11'h0); sb_q.push_back(ev(1,0,1,1,0,0,0,4'h0));
    for (int i = 0; i < 5; i++) begin
      cyc(32'h3C00_0000, 1'b0);
      e = sb_q.pop_front();
      n_checks++;
      if (obs !== e) begin n_errors++; $display("FAIL lw cyc%0d got %b exp %b", i+1, obs, e); end
    end
  endtask

  task automatic test_store;
    logic [10:0] e;
    sb_q.push_back(11'h0); sb_q.push_back(11'h0); sb_q.push_back(ev(0,0,0,0,0,0,1,4'h0));
    sb_q.push_back(ev(1,0,0,0,1,1,0,4'h0));
    for (int i = 0; i < 4; i++) begin
      cyc(32'h1C00_0000, 1'b0);
      e = sb_q.pop_front();
      n_checks++;
      if (obs !== e) begin n_errors++; $display("FAIL sb cyc%0d got %b exp %b", i+1, obs, e); end
      if (i == 1) begin
        n_checks++; if (RF_B_sel !== 1'b1) begin n_errors++; $display("FAIL sb_bsel got %b exp 1", RF_B_sel); end
      end
    end
  endtask

  task automatic test_branch;
    logic [10:0] e;
    // beq, Zero=1 -> taken
    sb_q.push_back(11'h0); sb_q.push_back(11'h0); sb_q.push_back(ev(1,1,0,0,0,0,0,4'h1));
    for (int i = 0; i < 3; i++) begin
      cyc(32'h0000_0000, 1'b1);
      e = sb_q.pop_front();
      n_checks++;
      if (obs !== e) begin n_errors++; $display("FAIL beq cyc%0d got %b exp %b", i+1, obs, e); end
    end
    // bne, Zero=1 -> not taken
    sb_q.push_back(11'h0); sb_q.push_back(11'h0); sb_q.push_back(ev(1,0,0,0,0,0,0,4'h1));
    for (int i = 0; i < 3; i++) begin
      cyc(32'h0400_0000, 1'b1);
      e = sb_q.pop_front();
      n_checks++;
      if (obs !== e) begin n_errors++; $display("FAIL bne cyc%0d got %b exp %b", i+1, obs, e); end
    end
  endtask

  task automatic test_back_to_back;
    logic [10:0] e;
    logic [31:0] ins [5];
    logic        zz  [5];
    ins[0] = 32'h8022_1805; zz[0] = 1'b0;  // ALU-R, func 0101
    ins[1] = 32'hC800_0000; zz[1] = 1'b0;  // andi
    ins[2] = 32'hCC00_0000; zz[2] = 1'b0;  // ori
    ins[3] = 32'hFC00_0000; zz[3] = 1'b1;  // b (always taken)
    ins[4] = 32'h0400_0000; zz[4] = 1'b0;  // bne, Zero=0 -> taken
    for (int k = 0; k < 5; k++) begin
      sb_q.push_back(11'h0); sb_q.push_back(11'h0);
      case (k)
        0: begin sb_q.push_back(ev(0,0,0,0,0,0,0,4'h5)); sb_q.push_back(ev(1,0,1,0,0,0,0,4'h0)); end
        1: begin sb_q.push_back(ev(0,0,0,0,0,0,1,4'h2)); sb_q.push_back(ev(1,0,1,0,0,0,0,4'h0)); end
        2: begin sb_q.push_back(ev(0,0,0,0,0,0,1,4'h3)); sb_q.push_back(ev(1,0,1,0,0,0,0,4'h0)); end
        default: sb_q.push_back(ev(1,1,0,0,0,0,0,4'h1));
      endcase
      while (sb_q.size() != 0) begin
        cyc(ins[k], zz[k]);
        e = sb_q.pop_front();
        n_checks++;
        if (obs !== e) begin n_errors++; $display("FAIL b2b instr%0d got %b exp %b", k, obs, e); end
      end
    end
  endtask

  task automatic test_illegal;
    logic [10:0] e;
    sb_q.push_back(11'h0); sb_q.push_back(ev(1,0,0,0,0,0,0,4'h0));
    for (int i = 0; i < 2; i++) begin
      cyc(32'h5400_0000, 1'b0);
      e = sb_q.pop_front();
      n_checks++;
      if (obs !== e)     begin n_errors++; $display("FAIL illegal_nop cyc%0d got %b exp %b", i+1, obs, e); end
      n_checks++;
      if (h_obs !== 11'h0) begin n_errors++; $display("FAIL illegal_halt cyc%0d got %b exp 0", i+1, h_obs); end
    end
    @(posedge Clk); #1;
    n_checks++; if (Illegal !== 1'b1)   begin n_errors++; $display("FAIL illegal_flag got %b exp 1", Illegal); end
    n_checks++; if (h_Illegal !== 1'b1) begin n_errors++; $display("FAIL illegal_flag_h got %b exp 1", h_Illegal); end
    // NOP variant keeps running; halting variant stays silent.
    sb_q.push_back(11'h0); sb_q.push_back(11'h0); sb_q.push_back(11'h0);
    sb_q.push_back(ev(1,0,1,0,0,0,0,4'h0));
    for (int i = 0; i < 4; i++) begin
      cyc(32'h8000_0000, 1'b0);
      e = sb_q.pop_front();
      n_checks++;
      if (obs !== e)     begin n_errors++; $display("FAIL post_illegal cyc%0d got %b exp %b", i+1, obs, e); end
      n_checks++;
      if (h_obs !== 11'h0) begin n_errors++; $display("FAIL halted cyc%0d got %b exp 0", i+1, h_obs); end
    end
    n_checks++; if (Illegal !== 1'b1) begin n_errors++; $display("FAIL illegal_sticky got %b exp 1", Illegal); end
  endtask

  task automatic test_reset_mid;
    logic [10:0] e;
    sb_q.push_back(11'h0); sb_q.push_back(11'h0); sb_q.push_back(ev(0,0,0,0,0,0,1,4'h0));
    for (int i = 0; i < 3; i++) begin
      cyc(32'h7C00_0000, 1'b0);
      e = sb_q.pop_front();
      n_checks++;
      if (obs !== e) begin n_errors++; $display("FAIL sw_pre cyc%0d got %b exp %b", i+1, obs, e); end
    end
    @(posedge Clk); #1;   // now in S_MEM of sw
    Reset = 1'b0;
    #1;
    n_checks++; if (obs !== 11'h0)      begin n_errors++; $display("FAIL rst_mid_outs got %b exp 0", obs); end
    n_checks++; if (IR !== 32'h0)       begin n_errors++; $display("FAIL rst_mid_ir got %h exp 0", IR); end
    n_checks++; if (Illegal !== 1'b0)   begin n_errors++; $display("FAIL rst_mid_illegal got %b exp 0", Illegal); end
    n_checks++; if (h_Illegal !== 1'b0) begin n_errors++; $display("FAIL rst_mid_illegal_h got %b exp 0", h_Illegal); end
    @(posedge Clk); #1;
    n_checks++; if (Mem_WrEn !== 1'b0)  begin n_errors++; $display("FAIL rst_mid_memwr got %b exp 0", Mem_WrEn); end
    @(posedge Clk); #2;
    Reset = 1'b1;
    sb_q.push_back(11'h0); sb_q.push_back(11'h0); sb_q.push_back(11'h0);
    sb_q.push_back(ev(1,0,1,0,0,0,0,4'h0));
    for (int i = 0; i < 4; i++) begin
      cyc(32'h8000_0000, 1'b0);
      e = sb_q.pop_front();
      n_checks++;
      if (obs !== e)   begin n_errors++; $display("FAIL restart cyc%0d got %b exp %b", i+1, obs, e); end
      n_checks++;
      if (h_obs !== e) begin n_errors++; $display("FAIL restart_h cyc%0d got %b exp %b", i+1, h_obs, e); end
    end
  endtask

  initial begin
    test_reset;
    test_alu_r;
    test_load;
    test_store;
    test_branch;
    test_back_to_back;
    test_illegal;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d checks", n_checks);
    $fatal(1, "timeout");
  end

endmodule
